bhand_fifo: RTL and testbench
=============================

Name: bhand_fifo

Overview:
- Parametrised successor to the single-stage buffered handshake: a DEPTH-entry valid/ready buffer with registered outputs.
- Decouples an upstream producer from a downstream consumer.
- Absorbs up to DEPTH words of backpressure.
- Sits anywhere in a streaming datapath where bhand sits today, but where more than one or two words of slack are needed.

Parameters:
DATA_WIDTH, 8, width of idata/odata in bits
ADDR_WIDTH, 2, log2 of storage depth; DEPTH = 2**ADDR_WIDTH entries; legal range 1..8

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
idata  input  DATA_WIDTH  upstream data
idata_vld  input  1  upstream word valid
idata_rdy  output  1  block can accept a word this cycle
odata  output  DATA_WIDTH  downstream data (head of buffer)
odata_vld  output  1  odata holds a valid word
odata_rdy  input  1  downstream accepts odata this cycle

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: rst high clears state immediately, independent of clk.
  - Clears wr_ptr, rd_ptr and occupancy count (ADDR_WIDTH+1 bits) to 0.
  - Forces idata_rdy=0 while rst is high; idata_rdy goes to 1 on the first edge after release.
  - odata_vld=0; odata=0.
  - Storage array contents are not reset.
- Push: idata_vld & idata_rdy at a rising edge.
  - Writes idata to mem[wr_ptr].
  - wr_ptr increments, wrapping modulo DEPTH.
- Pop: odata_vld & odata_rdy at a rising edge.
  - rd_ptr increments, wrapping modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Status outputs, all registered (no combinational path from any input to any output):
  - idata_rdy = (count_next != DEPTH).
  - odata_vld = (count_next != 0).
  - odata = mem[rd_ptr_next]; when the same edge writes that entry, the incoming idata is forwarded into the odata register.
- Latency: a word pushed into an empty buffer at edge N is visible with odata_vld=1 after edge N. No same-cycle fall-through.
- Throughput: one word per cycle sustained when odata_rdy is held high.
- Full (count==DEPTH): idata_rdy=0.
  - idata_vld is ignored and idata is not written.
  - A pop at that edge makes idata_rdy=1 for the next cycle.
  - Push and pop can never both occur at an edge where the buffer is full.
- Empty (count==0): odata_vld=0; odata_rdy is ignored. A push makes odata_vld=1 next cycle.
- Simultaneous push+pop with count in 1..DEPTH-1: count unchanged, both pointers advance; data order preserved.
- Ordering: strict FIFO. No word is dropped or duplicated.
- odata is stable while odata_vld=1 and odata_rdy=0 (AXI-stream style hold).
- Reset mid-operation: all buffered words are discarded. No output glitches to valid during or after reset.
- X-safety: idata_vld and odata_rdy must be 0 or 1 whenever sampled; idata may be X when idata_vld=0.

Optional Feature:
- Macro: BHAND_FIFO_COUNT_EN.
- Defined:
  - Adds output port `count`, width ADDR_WIDTH+1, driven directly from the occupancy register. Values 0..DEPTH; reset value 0.
  - Adds output `half_full`, 1 bit, registered, = (count_next >= DEPTH/2).
- Undefined:
  - Neither port exists.
  - The internal occupancy counter is still present, since it is used for full/empty.
  - Functional behaviour is otherwise identical.

Test Plan:
1. DATA_WIDTH=8, ADDR_WIDTH=2; reset, then push 0x11,0x22,0x33,0x44 with odata_rdy=0 -> idata_rdy=0 after 4th push; odata=0x11, odata_vld=1 held; 5th word 0x55 not accepted.
2. From full, odata_rdy=1 for 4 cycles, idata_vld=0 -> odata sequence 0x11,0x22,0x33,0x44; then odata_vld=0; idata_rdy=1 from the cycle after the first pop.
3. idata_vld=1 and odata_rdy=1 continuously with incrementing data 0x00..0x1F -> after 1-cycle latency, odata_vld stays 1 and odata increments by 1 every cycle; count stays 1; pointers wrap several times with no gaps.
4. Random idata_vld/odata_rdy (50% each), 1000 words -> output stream equals input stream exactly; idata_rdy and odata_vld never toggle combinationally with inputs.
5. Push 3 words, assert rst asynchronously mid-cycle for 2 cycles -> odata_vld=0 and idata_rdy=0 immediately; after release, idata_rdy=1 next edge and no stale word appears.
6. With BHAND_FIFO_COUNT_EN, ADDR_WIDTH=3: push 5 words, pop 1 -> count 1,2,3,4,5 then 4; half_full asserts when count reaches 4 and stays 1 after the pop.

Source files
------------

// File: rtl/bhand_fifo.sv
// bhand_fifo: DEPTH-entry valid/ready buffer with registered outputs.
// DEPTH = 2**ADDR_WIDTH. idata_rdy, odata_vld and odata are all registered.
// Optional feature, enabled by defining BHAND_FIFO_COUNT_EN, adds the
// occupancy output `count` and the registered flag `half_full`.
module bhand_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  idata_vld,
  output logic                  idata_rdy,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  odata_vld,
  input  logic                  odata_rdy
`ifdef BHAND_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  half_full
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LP_ZERO  = '0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_idata_rdy;
  logic                  r_odata_vld;
  logic [DATA_WIDTH-1:0] r_odata;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_odata_next;

  // Handshakes use only registered status, so nothing combinational reaches an output.
  assign w_push = idata_vld & r_idata_rdy;
  assign w_pop  = r_odata_vld & odata_rdy;

  // Next-state pointers, occupancy and the word that will sit at the head.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count;
    if (w_push) w_wr_ptr_next = r_wr_ptr + 1'b1;
    if (w_pop)  w_rd_ptr_next = r_rd_ptr + 1'b1;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
    // The entry becoming the head is being written this edge: take idata directly.
    w_fwd        = w_push && (r_wr_ptr == w_rd_ptr_next);
    w_odata_next = w_fwd ? idata : r_mem[w_rd_ptr_next];
  end

  // Storage write on push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy alone decides which entries are live.
    if (w_push) r_mem[r_wr_ptr] <= idata;
  end

  // Pointers, occupancy and registered status/data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_idata_rdy <= 1'b0;
      r_odata_vld <= 1'b0;
      r_odata     <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_idata_rdy <= (w_count_next != LP_DEPTH);
      r_odata_vld <= (w_count_next != LP_ZERO);
      r_odata     <= w_odata_next;
    end
  end

  assign idata_rdy = r_idata_rdy;
  assign odata_vld = r_odata_vld;
  assign odata     = r_odata;

`ifdef BHAND_FIFO_COUNT_EN
  localparam logic [ADDR_WIDTH:0] LP_HALF = LP_DEPTH >> 1;

  logic r_half_full;

  // Registered half-full flag computed from next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_half_full <= 1'b0;
    else     r_half_full <= (w_count_next >= LP_HALF);
  end

  assign count     = r_count;
  assign half_full = r_half_full;
`endif

endmodule

// File: tb/tb_bhand_fifo.sv
// Self-checking bench for bhand_fifo: vector table for fill/drain/forwarding,
// then streaming, random traffic against a queue model, and async reset.
// With BHAND_FIFO_COUNT_EN defined a second ADDR_WIDTH=3 instance checks count/half_full.
module tb_bhand_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] idata = '0;
  logic       idata_vld = 1'b0;
  logic       idata_rdy;
  logic [7:0] odata;
  logic       odata_vld;
  logic       odata_rdy = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bhand_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .idata     (idata),
    .idata_vld (idata_vld),
    .idata_rdy (idata_rdy),
    .odata     (odata),
    .odata_vld (odata_vld),
    .odata_rdy (odata_rdy)
  );

`ifdef BHAND_FIFO_COUNT_EN
  logic [7:0] idata3 = '0;
  logic       idata_vld3 = 1'b0;
  logic       idata_rdy3;
  logic [7:0] odata3;
  logic       odata_vld3;
  logic       odata_rdy3 = 1'b0;
  logic [3:0] count3;
  logic       half_full3;

  bhand_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .idata     (idata3),
    .idata_vld (idata_vld3),
    .idata_rdy (idata_rdy3),
    .odata     (odata3),
    .odata_vld (odata_vld3),
    .odata_rdy (odata_rdy3),
    .count     (count3),
    .half_full (half_full3)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       ordy;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [7:0] q[$];
    int         popped;
    int         cycles;
    int         m_count;
    logic       push;
    logic       pop;
    logic [7:0] next_word;

    // Fill to full, blocked 5th word, full with both sides active, drain,
    // pop while empty, then a push+pop at count 1 that needs forwarding.
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h22};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 8'h66};
    vecs[12] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    // Reset state while clock runs.
    repeat (2) tick();
    check("reset idata_rdy", 32'(idata_rdy), 32'd0);
    check("reset odata_vld", 32'(odata_vld), 32'd0);
    check("reset odata",     32'(odata),     32'd0);
    rst = 1'b0;

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      idata     = vecs[i].data;
      idata_vld = vecs[i].vld;
      odata_rdy = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d idata_rdy", i), 32'(idata_rdy), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d odata_vld", i), 32'(odata_vld), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld)
        check($sformatf("vec%0d odata", i), 32'(odata), 32'(vecs[i].e_data));
    end

    // Streaming: one word per cycle, one cycle latency, pointers wrap.
    idata_vld = 1'b1;
    odata_rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      idata = 8'(i);
      tick();
      check($sformatf("stream%0d odata_vld", i), 32'(odata_vld), 32'd1);
      check($sformatf("stream%0d odata", i),     32'(odata),     32'(i));
      check($sformatf("stream%0d idata_rdy", i), 32'(idata_rdy), 32'd1);
    end
    idata_vld = 1'b0;
    tick();
    check("stream drain odata_vld", 32'(odata_vld), 32'd0);
    odata_rdy = 1'b0;

    // Random traffic against a queue model; checks land after new inputs
    // are applied so any combinational input->output path shows up.
    m_count   = 0;
    popped    = 0;
    cycles    = 0;
    next_word = 8'h00;
    while (popped < 1000 && cycles < 20000) begin
      idata_vld = 1'($urandom_range(0, 1));
      odata_rdy = 1'($urandom_range(0, 1));
      idata     = next_word;
      #1;
      check("rand idata_rdy", 32'(idata_rdy), 32'(m_count != 4));
      check("rand odata_vld", 32'(odata_vld), 32'(m_count != 0));
      if (m_count != 0) check("rand odata", 32'(odata), 32'(q[0]));
      push = idata_vld && (m_count != 4);
      pop  = odata_rdy && (m_count != 0);
      @(posedge clk);
      if (pop) begin
        void'(q.pop_front());
        popped++;
        m_count--;
      end
      if (push) begin
        q.push_back(next_word);
        next_word = next_word + 8'h01;
        m_count++;
      end
      #1;
      cycles++;
    end
    check("rand words popped", 32'(popped), 32'd1000);

    // Async reset mid-cycle with words buffered; nothing stale after release.
    idata_vld = 1'b0;
    odata_rdy = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    odata_rdy = 1'b0;
    idata_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idata = 8'hC0 + 8'(i);
      tick();
    end
    idata_vld = 1'b0;
    check("pre-reset odata_vld", 32'(odata_vld), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset idata_rdy", 32'(idata_rdy), 32'd0);
    check("async reset odata_vld", 32'(odata_vld), 32'd0);
    check("async reset odata",     32'(odata),     32'd0);
    tick();
    tick();
    check("held reset idata_rdy", 32'(idata_rdy), 32'd0);
    check("held reset odata_vld", 32'(odata_vld), 32'd0);
    rst = 1'b0;
    odata_rdy = 1'b1;
    tick();
    check("post-reset idata_rdy", 32'(idata_rdy), 32'd1);
    check("post-reset odata_vld", 32'(odata_vld), 32'd0);
    odata_rdy = 1'b0;
    idata_vld = 1'b1;
    idata     = 8'hA5;
    tick();
    idata_vld = 1'b0;
    check("post-reset first odata_vld", 32'(odata_vld), 32'd1);
    check("post-reset first odata",     32'(odata),     32'hA5);
    odata_rdy = 1'b1;
    tick();
    check("post-reset drained", 32'(odata_vld), 32'd0);
    odata_rdy = 1'b0;

`ifdef BHAND_FIFO_COUNT_EN
    // Occupancy and half_full on an 8-deep instance.
    check("cnt3 idle count", 32'(count3), 32'd0);
    idata_vld3 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      idata3 = 8'(i);
      tick();
      check($sformatf("cnt3 push%0d count", i),     32'(count3),     32'(i));
      check($sformatf("cnt3 push%0d half_full", i), 32'(half_full3), 32'(i >= 4));
    end
    idata_vld3 = 1'b0;
    odata_rdy3 = 1'b1;
    tick();
    odata_rdy3 = 1'b0;
    check("cnt3 pop count",     32'(count3),     32'd4);
    check("cnt3 pop half_full", 32'(half_full3), 32'd1);
    check("cnt3 pop odata",     32'(odata3),     32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
